// File: rtl/wb_dma_pkg.sv
// Shared definitions for the multi-channel Wishbone DMA: register map,
// CSR bit positions and copy-engine state encoding.
package wb_dma_pkg;

  localparam logic [1:0] REG_CSR = 2'd0;
  localparam logic [1:0] REG_RSV = 2'd1;
  localparam logic [1:0] REG_M0A = 2'd2;
  localparam logic [1:0] REG_M1A = 2'd3;

  localparam int CSR_DIR    = 16;
  localparam int CSR_M0_INC = 17;
  localparam int CSR_M1_INC = 18;
  localparam int CSR_IRQ_EN = 19;
  localparam int CSR_DONE   = 29;
  localparam int CSR_ABORT  = 30;
  localparam int CSR_BUSY   = 30;
  localparam int CSR_GO     = 31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } eng_state_t;

endpackage

// File: rtl/wb_dma_ch.sv
// One DMA channel register set: config, address/length counters,
// busy/done status and CSR readback.
module wb_dma_ch
  import wb_dma_pkg::*;
#(
  parameter int A0W = 9,
  parameter int A1W = 9,
  parameter int DW  = 32,
  parameter int LW  = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           csr_we,
  input  logic           m0a_we,
  input  logic           m1a_we,
  input  logic [DW-1:0]  wdata,
  input  logic           sel,
  input  logic           serve,
  output logic           busy,
  output logic           dir,
  output logic           irq_pend,
  output logic [A0W-1:0] m0_addr,
  output logic [A1W-1:0] m1_addr,
  output logic [DW-1:0]  csr_rd
);

  logic [LW:0] len;
  logic [LW:0] len_dec;
  logic        m0_inc, m1_inc, irq_en, done, abort_pend;
  logic        go, abort_req, w1c, last_word;
  logic        unused_wdata;

  assign go        = csr_we & wdata[CSR_GO] & ~wdata[CSR_ABORT];
  assign abort_req = csr_we & wdata[CSR_ABORT];
  assign w1c       = csr_we & wdata[CSR_DONE];
  assign len_dec   = len - {{LW{1'b0}}, 1'b1};
  assign last_word = serve & len_dec[LW];
  assign unused_wdata = ^wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len        <= '0;
      dir        <= 1'b0;
      m0_inc     <= 1'b0;
      m1_inc     <= 1'b0;
      irq_en     <= 1'b0;
      busy       <= 1'b0;
      abort_pend <= 1'b0;
      m0_addr    <= '0;
      m1_addr    <= '0;
    end else if (serve) begin
      m0_addr <= m0_addr + A0W'(m0_inc);
      m1_addr <= m1_addr + A1W'(m1_inc);
      len     <= len_dec;
      if (len_dec[LW] || abort_pend || abort_req) begin
        busy       <= 1'b0;
        abort_pend <= 1'b0;
      end
    end else if (busy) begin
      // The served channel must finish its in-flight word before stopping
      if (abort_req) begin
        if (sel) abort_pend <= 1'b1;
        else     busy       <= 1'b0;
      end
    end else begin
      if (m0a_we) m0_addr <= wdata[A0W-1:0];
      if (m1a_we) m1_addr <= wdata[A1W-1:0];
      if (go) begin
        len    <= {1'b0, wdata[LW-1:0]};
        dir    <= wdata[CSR_DIR];
        m0_inc <= wdata[CSR_M0_INC];
        m1_inc <= wdata[CSR_M1_INC];
        irq_en <= wdata[CSR_IRQ_EN];
        busy   <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                done <= 1'b0;
    else if (last_word)     done <= 1'b1;
    else if (go && !busy)   done <= 1'b0;
    else if (w1c)           done <= 1'b0;
  end

  always_comb begin
    csr_rd             = '0;
    csr_rd[LW-1:0]     = len[LW-1:0];
    csr_rd[CSR_DIR]    = dir;
    csr_rd[CSR_M0_INC] = m0_inc;
    csr_rd[CSR_M1_INC] = m1_inc;
    csr_rd[CSR_IRQ_EN] = irq_en;
    csr_rd[CSR_DONE]   = done;
    csr_rd[CSR_BUSY]   = busy;
  end

  assign irq_pend = done & irq_en;

endmodule

// File: rtl/wb_dma_mc.sv
// Multi-channel Wishbone DMA: control slave, round-robin arbiter and a
// single word-at-a-time copy engine shared by all channels.
//
//   state   | meaning
//   IDLE    | pick next busy channel after the last served one
//   RD      | read one word from the source port
//   WR      | write the held word to the destination port, update channel
module wb_dma_mc
  import wb_dma_pkg::*;
#(
  parameter int A0W = 9,
  parameter int A1W = 9,
  parameter int DW  = 32,
  parameter int LW  = 12,
  parameter int NCH = 4,
  localparam int CW = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           rst,
  output logic [A0W-1:0] m0_addr,
  output logic [DW-1:0]  m0_wdata,
  output logic           m0_we,
  output logic           m0_cyc,
  input  logic [DW-1:0]  m0_rdata,
  input  logic           m0_ack,
  output logic [A1W-1:0] m1_addr,
  output logic [DW-1:0]  m1_wdata,
  output logic           m1_we,
  output logic           m1_cyc,
  input  logic [DW-1:0]  m1_rdata,
  input  logic           m1_ack,
  input  logic [CW+1:0]  ctl_addr,
  input  logic [DW-1:0]  ctl_wdata,
  input  logic           ctl_we,
  input  logic           ctl_cyc,
  output logic [DW-1:0]  ctl_rdata,
  output logic           ctl_ack,
  output logic           irq
);

  logic [NCH-1:0]          ch_busy, ch_dir, ch_irq, sel, serve;
  logic [NCH-1:0][A0W-1:0] ch_m0a;
  logic [NCH-1:0][A1W-1:0] ch_m1a;
  logic [NCH-1:0][DW-1:0]  ch_csr;

  eng_state_t    state, nxt;
  logic [CW-1:0] cur, last, grant;
  logic          grant_vld;
  logic [DW-1:0] data;
  logic          dir_cur, src_ack, dst_ack;

  logic          ctl_req, ctl_wr;
  logic [CW-1:0] ctl_ch;
  logic [1:0]    ctl_reg;
  logic [DW-1:0] rd_mux;

  assign ctl_req = ctl_cyc & ~ctl_ack;
  assign ctl_wr  = ctl_req & ctl_we;
  assign ctl_ch  = ctl_addr[CW+1:2];
  assign ctl_reg = ctl_addr[1:0];

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    wb_dma_ch #(.A0W(A0W), .A1W(A1W), .DW(DW), .LW(LW)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .csr_we   (ctl_wr && ctl_ch == CW'(i) && ctl_reg == REG_CSR),
      .m0a_we   (ctl_wr && ctl_ch == CW'(i) && ctl_reg == REG_M0A),
      .m1a_we   (ctl_wr && ctl_ch == CW'(i) && ctl_reg == REG_M1A),
      .wdata    (ctl_wdata),
      .sel      (sel[i]),
      .serve    (serve[i]),
      .busy     (ch_busy[i]),
      .dir      (ch_dir[i]),
      .irq_pend (ch_irq[i]),
      .m0_addr  (ch_m0a[i]),
      .m1_addr  (ch_m1a[i]),
      .csr_rd   (ch_csr[i])
    );
  end

  always_comb begin
    rd_mux = '0;
    case (ctl_reg)
      REG_CSR: rd_mux = ch_csr[ctl_ch];
      REG_M0A: rd_mux = DW'(ch_m0a[ctl_ch]);
      REG_M1A: rd_mux = DW'(ch_m1a[ctl_ch]);
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_ack   <= 1'b0;
      ctl_rdata <= '0;
      irq       <= 1'b0;
    end else begin
      ctl_ack   <= ctl_req;
      ctl_rdata <= ctl_req ? rd_mux : '0;
      irq       <= |ch_irq;
    end
  end

  // Scan descending so the closest busy channel after 'last' wins
  always_comb begin
    logic [CW-1:0] idx;
    idx       = '0;
    grant     = '0;
    grant_vld = 1'b0;
    for (int k = NCH; k >= 1; k--) begin
      idx = last + CW'(k);
      if (ch_busy[idx]) begin
        grant     = idx;
        grant_vld = 1'b1;
      end
    end
  end

  assign dir_cur = ch_dir[cur];
  assign src_ack = dir_cur ? m1_ack : m0_ack;
  assign dst_ack = dir_cur ? m0_ack : m1_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cur   <= '0;
      last  <= '0;
      data  <= '0;
    end else begin
      state <= nxt;
      if (state == ST_IDLE && grant_vld) begin
        cur  <= grant;
        last <= grant;
      end
      if (state == ST_RD && src_ack) data <= dir_cur ? m1_rdata : m0_rdata;
    end
  end

  always_comb begin
    nxt    = state;
    m0_cyc = 1'b0;
    m0_we  = 1'b0;
    m1_cyc = 1'b0;
    m1_we  = 1'b0;
    serve  = '0;
    sel    = '0;
    case (state)
      ST_IDLE: begin
        if (grant_vld) begin
          sel[grant] = 1'b1;
          nxt        = ST_RD;
        end
      end
      ST_RD: begin
        sel[cur] = 1'b1;
        if (dir_cur) m1_cyc = 1'b1;
        else         m0_cyc = 1'b1;
        if (src_ack) nxt = ST_WR;
      end
      ST_WR: begin
        sel[cur] = 1'b1;
        if (dir_cur) begin
          m0_cyc = 1'b1;
          m0_we  = 1'b1;
        end else begin
          m1_cyc = 1'b1;
          m1_we  = 1'b1;
        end
        if (dst_ack) begin
          serve[cur] = 1'b1;
          nxt        = ST_IDLE;
        end
      end
      default: nxt = ST_IDLE;
    endcase
  end

  assign m0_addr  = ch_m0a[cur];
  assign m1_addr  = ch_m1a[cur];
  assign m0_wdata = data;
  assign m1_wdata = data;

endmodule
